// File: rtl/cs_common_pkg.sv
// Shared types for the co-simulation fringe clocking blocks.
package cs_common;
  localparam int unsigned CS_N_CLK_MAX = 4;

  typedef enum logic [1:0] {
    CS_CK_PARK,
    CS_CK_RUN,
    CS_CK_STALL,
    CS_CK_DRAIN
  } cs_ck_state_t;

  typedef logic [15:0] cs_edge_cnt_t;
endpackage

// File: rtl/cs_clk_chan.sv
// One mission-clock channel: run/stall/drain FSM, half-period divider,
// rising-edge counter and freeze watchdog.
module cs_clk_chan
  import cs_common::*;
#(
  parameter int unsigned      CNT_W       = 8,
  parameter logic [CNT_W-1:0] HALF_PER    = CNT_W'(2),
  parameter logic [15:0]      FRZ_TIMEOUT = 16'd10000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        freeze_clk,
  output logic        clk_h_o,
  output logic        rise_o,
  output logic        frozen_o,
  output logic [15:0] edge_cnt_o,
  output logic        frz_timeout_o
);
  localparam logic [CNT_W-1:0] LAST = HALF_PER - CNT_W'(1);

  cs_ck_state_t     state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      frz_cnt, frz_inc;
  cs_edge_cnt_t     edge_q;
  logic             cnt_en, wrap;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= CS_CK_PARK;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      CS_CK_PARK:  if (en_i) nxt = CS_CK_RUN;
      CS_CK_RUN: begin
        if (freeze_clk) nxt = CS_CK_STALL;
        else if (!en_i) nxt = (clk_h_o && !wrap) ? CS_CK_DRAIN : CS_CK_PARK;
      end
      CS_CK_STALL: if (!freeze_clk) nxt = CS_CK_RUN;
      CS_CK_DRAIN: begin
        if (freeze_clk) nxt = CS_CK_STALL;
        else if (wrap)  nxt = CS_CK_PARK;
      end
      default: nxt = CS_CK_PARK;
    endcase
  end

  // Freeze is a registered response: the edge that first samples it still
  // counts, and the edge that samples its release counts again, so the
  // interrupted phase keeps exactly HALF_PER counting edges.
  always_comb begin
    cnt_en = 1'b0;
    unique case (state)
      CS_CK_RUN:   cnt_en = en_i || clk_h_o;
      CS_CK_DRAIN: cnt_en = 1'b1;
      CS_CK_STALL: cnt_en = !freeze_clk && (en_i || clk_h_o);
      default:     cnt_en = 1'b0;
    endcase
  end

  assign wrap    = cnt_en && (cnt == LAST);
  assign frz_inc = frz_cnt + 16'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt           <= '0;
      clk_h_o       <= 1'b0;
      rise_o        <= 1'b0;
      frozen_o      <= 1'b0;
      edge_q        <= '0;
      frz_cnt       <= '0;
      frz_timeout_o <= 1'b0;
    end else begin
      rise_o   <= wrap && !clk_h_o;
      frozen_o <= (nxt == CS_CK_STALL);
      if (nxt == CS_CK_PARK) cnt <= '0;
      else if (wrap)         cnt <= '0;
      else if (cnt_en)       cnt <= cnt + CNT_W'(1);
      if (wrap) clk_h_o <= !clk_h_o;
      if (wrap && !clk_h_o) edge_q <= edge_q + 16'd1;
      if (nxt == CS_CK_STALL) begin
        if (frz_cnt != '1) begin
          frz_cnt <= frz_inc;
          if (frz_inc == FRZ_TIMEOUT) frz_timeout_o <= 1'b1;
        end
      end else begin
        frz_cnt <= '0;
      end
    end
  end

  assign edge_cnt_o = edge_q;
endmodule

// File: rtl/cs_mission_clk_gen.sv
// Target-side mission-clock generator: N_CLK independent divided clocks
// with per-channel freeze back-pressure from the fringe interface.
module cs_mission_clk_gen
  import cs_common::*;
#(
  parameter int unsigned            N_CLK       = 4,
  parameter int unsigned            CNT_W       = 8,
  parameter logic [N_CLK*CNT_W-1:0] HALF_PER    = {8'd8, 8'd6, 8'd4, 8'd2},
  parameter logic [15:0]            FRZ_TIMEOUT = 16'd10000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [N_CLK-1:0]    freeze_clk,
  output logic [N_CLK-1:0]    clk_h_o,
  output logic [N_CLK-1:0]    rise_o,
  output logic [N_CLK-1:0]    frozen_o,
  output logic [N_CLK*16-1:0] edge_cnt_o,
  output logic [N_CLK-1:0]    frz_timeout_o
);
  if (N_CLK < 1 || N_CLK > CS_N_CLK_MAX) begin : g_bad_n
    $error("cs_mission_clk_gen: N_CLK=%0d out of range", N_CLK);
  end

  for (genvar k = 0; k < N_CLK; k++) begin : g_ch
    localparam logic [CNT_W-1:0] HP = HALF_PER[k*CNT_W +: CNT_W];

    // A half-period below 2 lets the clock fall before a fringe freeze lands.
    if (HP < 2) begin : g_bad_hp
      $error("cs_mission_clk_gen: HALF_PER[%0d]=%0d, must be >= 2", k, HP);
    end

    cs_clk_chan #(
      .CNT_W      (CNT_W),
      .HALF_PER   (HP),
      .FRZ_TIMEOUT(FRZ_TIMEOUT)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .en_i         (en_i),
      .freeze_clk   (freeze_clk[k]),
      .clk_h_o      (clk_h_o[k]),
      .rise_o       (rise_o[k]),
      .frozen_o     (frozen_o[k]),
      .edge_cnt_o   (edge_cnt_o[k*16 +: 16]),
      .frz_timeout_o(frz_timeout_o[k])
    );
  end
endmodule

// File: tb/tb_cs_mission_clk_gen.sv
// Directed bench for cs_mission_clk_gen: free run, freeze/release,
// watchdog, drain on disable and async reset mid-stall.
module tb_cs_mission_clk_gen;
  localparam int N = 4;
  localparam int HP [N] = '{2, 4, 6, 8};

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            en_i = 1'b0;
  logic [N-1:0]    freeze_clk = '0;
  logic [N-1:0]    clk_h_o, rise_o, frozen_o, frz_timeout_o;
  logic [N*16-1:0] edge_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  cs_mission_clk_gen #(
    .N_CLK      (N),
    .CNT_W      (8),
    .HALF_PER   ({8'd8, 8'd6, 8'd4, 8'd2}),
    .FRZ_TIMEOUT(16'd16)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .freeze_clk   (freeze_clk),
    .clk_h_o      (clk_h_o),
    .rise_o       (rise_o),
    .frozen_o     (frozen_o),
    .edge_cnt_o   (edge_cnt_o),
    .frz_timeout_o(frz_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // cyc = number of the edge just passed; edge 0 is the first one after reset release
  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // Free-running channel k rises at HP, 3*HP, ... and falls at 2*HP, 4*HP, ...
  function automatic logic [N-1:0] exp_clk(input int n);
    logic [N-1:0] e;
    for (int k = 0; k < N; k++) e[k] = (n >= 0) && (((n / HP[k]) % 2) == 1);
    return e;
  endfunction

  function automatic logic [N-1:0] exp_rise(input int n);
    logic [N-1:0] e;
    for (int k = 0; k < N; k++) e[k] = (n > 0) && (n % HP[k] == 0) && (((n / HP[k]) % 2) == 1);
    return e;
  endfunction

  task automatic restart();
    rst_ni     = 1'b0;
    en_i       = 1'b1;
    freeze_clk = '0;
    @(posedge clk_i);
    #1;
    chk("rst_clk", clk_h_o, 0);
    chk("rst_rise", rise_o, 0);
    chk("rst_frz", frozen_o, 0);
    chk("rst_ec", edge_cnt_o, 0);
    chk("rst_wdog", frz_timeout_o, 0);
    rst_ni = 1'b1;
    cyc    = -1;
  endtask

  initial begin
    // 1+2: reset, then free run; periods 4/8/12/16
    restart();
    while (cyc < 40) begin
      step();
      chk("run_clk", clk_h_o, exp_clk(cyc));
      chk("run_rise", rise_o, exp_rise(cyc));
    end
    chk("run_ec0", edge_cnt_o[15:0], 16'd10);
    chk("run_ec1", edge_cnt_o[31:16], 16'd5);
    chk("run_ec2", edge_cnt_o[47:32], 16'd3);
    chk("run_ec3", edge_cnt_o[63:48], 16'd3);

    // 3: ch1 rises at 44, freeze seen at 45, released (seen low) at 65
    while (cyc < 44) step();
    freeze_clk[1] = 1'b1;
    while (cyc < 71) begin
      step();
      if (cyc == 64) freeze_clk[1] = 1'b0;
      chk("frz1_oth", clk_h_o & 4'b1101, exp_clk(cyc) & 4'b1101);
      chk("frz1_clk", clk_h_o[1], (cyc < 67 || cyc == 71) ? 1'b1 : 1'b0);
      chk("frz1_rise", rise_o[1], cyc == 71);
      chk("frz1_frozen", frozen_o, (cyc <= 64) ? 4'b0010 : 4'b0000);
      chk("frz1_wdog", frz_timeout_o, (cyc >= 60) ? 4'b0010 : 4'b0000);
    end
    chk("frz1_ec1", edge_cnt_o[31:16], 16'd7);
    chk("frz1_ec0", edge_cnt_o[15:0], 16'd18);

    // 4: watchdog on ch0, stalled from edge 3 through 32
    restart();
    while (cyc < 2) step();
    freeze_clk[0] = 1'b1;
    while (cyc < 36) begin
      step();
      if (cyc == 32) freeze_clk[0] = 1'b0;
      chk("wd_clk0", clk_h_o[0], (cyc <= 32 || cyc >= 35) ? 1'b1 : 1'b0);
      chk("wd_frozen", frozen_o[0], cyc <= 32);
      chk("wd_flag", frz_timeout_o, (cyc >= 18) ? 4'b0001 : 4'b0000);
    end
    chk("wd_ec0", edge_cnt_o[15:0], 16'd2);

    // 5: drop en_i while ch3 is mid-high; every high phase finishes, then park
    restart();
    chk("dr_wdog_clr", frz_timeout_o, 0);
    while (cyc < 10) begin
      step();
      chk("dr_pre", clk_h_o, exp_clk(cyc));
    end
    en_i = 1'b0;
    while (cyc < 40) begin
      step();
      chk("dr_clk", clk_h_o, (cyc == 11) ? 4'b1101 : (cyc <= 15) ? 4'b1000 : 4'b0000);
      chk("dr_rise", rise_o, 0);
    end
    chk("dr_ec", edge_cnt_o, {16'd1, 16'd1, 16'd1, 16'd3});

    // 6: freeze ch0 and ch2 together, then async reset mid-stall
    restart();
    while (cyc < 6) step();
    freeze_clk = 4'b0101;
    while (cyc < 10) begin
      step();
      chk("rs_frozen", frozen_o, 4'b0101);
      chk("rs_held", clk_h_o & 4'b0101, 4'b0101);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rs_async_clk", clk_h_o, 0);
    chk("rs_async_frz", frozen_o, 0);
    chk("rs_async_ec", edge_cnt_o, 0);
    chk("rs_async_rise", rise_o, 0);
    freeze_clk = '0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cyc    = -1;
    while (cyc < 4) begin
      step();
      chk("rs_rerun", clk_h_o, exp_clk(cyc));
      chk("rs_rerise", rise_o, exp_rise(cyc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
